// File: rtl/instruction_predecoder.sv
// Prefetch queue consumer: delimits one V33 instruction per handshake.
// Ports: clk/n_reset, ce_1/ce_2 strobes, ipq/ipq_len in, ipq_head/pfp_set out,
//        br_req/br_target in, dec_valid/dec_ready handshake, dec_* fields out.
module instruction_predecoder #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            ce_1,
    input  logic            ce_2,
    input  logic [7:0][7:0] ipq,
    input  logic [3:0]      ipq_len,
    output logic [15:0]     ipq_head,
    output logic            pfp_set,
    input  logic            br_req,
    input  logic [15:0]     br_target,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [15:0]     dec_pc,
    output logic [3:0]      dec_len,
    output logic [2:0]      dec_seg,
    output logic [1:0]      dec_rep,
    output logic            dec_lock,
    output logic [7:0]      dec_opcode,
    output logic            dec_has_modrm,
    output logic [7:0]      dec_modrm,
    output logic [15:0]     dec_disp,
    output logic [15:0]     dec_imm,
    output logic [15:0]     dec_imm2,
    output logic            dec_illegal
);

    typedef enum logic [2:0] {
        S_PREFIX,
        S_MODRM,
        S_DISP,
        S_IMM,
        S_HOLD
    } state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  len;
        logic [2:0]  seg;
        logic [1:0]  rep;
        logic        lock;
        logic [7:0]  opcode;
        logic        has_modrm;
        logic [7:0]  modrm;
        logic [15:0] disp;
        logic [15:0] imm;
        logic [15:0] imm2;
        logic        illegal;
    } dec_t;

    function automatic logic op_has_modrm(input logic [7:0] op);
        return ((op[7:6] == 2'b00) && !op[2])
            || (op == 8'h62) || (op == 8'h69) || (op == 8'h6B)
            || (op[7:4] == 4'h8)
            || (op == 8'hC0) || (op == 8'hC1)
            || (op == 8'hC4) || (op == 8'hC5)
            || (op == 8'hC6) || (op == 8'hC7)
            || (op[7:2] == 6'b110100)
            || (op[7:3] == 5'b11011)
            || (op == 8'hF6) || (op == 8'hF7)
            || (op == 8'hFE) || (op == 8'hFF);
    endfunction

    // F6/F7 immediates depend on ModRM.reg and are added in S_MODRM.
    function automatic logic [2:0] op_imm_bytes(input logic [7:0] op);
        logic [2:0] n;
        n = 3'd0;
        if ((op[7:6] == 2'b00) && (op[2:1] == 2'b10))
            n = op[0] ? 3'd2 : 3'd1;
        if (op[7:4] == 4'h7)
            n = 3'd1;
        if (op[7:3] == 5'b10110)
            n = 3'd1;
        if (op[7:3] == 5'b10111)
            n = 3'd2;
        if (op[7:3] == 5'b11100)
            n = 3'd1;
        case (op)
            8'h6A, 8'h6B, 8'h80, 8'h82, 8'h83, 8'hA8,
            8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'hD4, 8'hD5,
            8'hEB:
                n = 3'd1;
            8'h68, 8'h69, 8'h81, 8'hA9, 8'hC2, 8'hC7,
            8'hCA, 8'hE8, 8'hE9:
                n = 3'd2;
            8'hC8:
                n = 3'd3;
            8'h9A, 8'hEA:
                n = 3'd4;
            default: ;
        endcase
        return n;
    endfunction

    state_e      state_q, state_d, cur;
    logic [15:0] head_q, head_d;
    logic        pfp_q, pfp_d;
    logic        valid_q, valid_d;
    dec_t        f_q, f_d;
    logic [1:0]  disp_n_q, disp_n_d;
    logic [2:0]  imm_n_q, imm_n_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  ib;
    logic        take;
    logic        sx;

    assign ib = ipq[head_q[2:0]];
    assign sx = (f_q.opcode == 8'h83) || (f_q.opcode == 8'h6B)
             || (f_q.opcode == 8'h6A);

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        pfp_d    = pfp_q;
        valid_d  = valid_q;
        f_d      = f_q;
        disp_n_d = disp_n_q;
        imm_n_d  = imm_n_q;
        cnt_d    = cnt_q;
        cur      = state_q;

        // Accept and the next byte share one ce_1 (zero bubble).
        if (ce_1 && (state_q == S_HOLD) && valid_q && dec_ready) begin
            f_d     = '0;
            valid_d = 1'b0;
            cur     = S_PREFIX;
            state_d = S_PREFIX;
        end

        take = ce_1 && !pfp_q && (ipq_len != 4'd0) && (cur != S_HOLD);

        if (take) begin
            head_d = head_q + 16'd1;
            if (f_d.len == 4'd0)
                f_d.pc = head_q;
            if (f_d.len != 4'hF)
                f_d.len = f_d.len + 4'd1;
            unique case (cur)
                S_PREFIX: begin
                    if ((ib[7:5] == 3'b001) && (ib[2:0] == 3'b110)) begin
                        f_d.seg = {1'b1, ib[4:3]};
                    end else if (ib == 8'hF2) begin
                        f_d.rep = 2'b10;
                    end else if (ib == 8'hF3) begin
                        f_d.rep = 2'b11;
                    end else if (ib == 8'hF0) begin
                        f_d.lock = 1'b1;
                    end else if (ib == 8'h0F) begin
                        f_d.opcode  = ib;
                        f_d.illegal = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        f_d.opcode    = ib;
                        f_d.has_modrm = op_has_modrm(ib);
                        imm_n_d       = op_imm_bytes(ib);
                        cnt_d         = 2'd0;
                        if (f_d.has_modrm)
                            state_d = S_MODRM;
                        else if (imm_n_d != 3'd0)
                            state_d = S_IMM;
                        else
                            state_d = S_HOLD;
                    end
                end
                S_MODRM: begin
                    f_d.modrm = ib;
                    unique case (ib[7:6])
                        2'b00:   disp_n_d = (ib[2:0] == 3'b110) ? 2'd2 : 2'd0;
                        2'b01:   disp_n_d = 2'd1;
                        2'b10:   disp_n_d = 2'd2;
                        default: disp_n_d = 2'd0;
                    endcase
                    if ((f_q.opcode[7:1] == 7'b1111011) && (ib[5:3] == 3'b000))
                        imm_n_d = f_q.opcode[0] ? 3'd2 : 3'd1;
                    cnt_d = 2'd0;
                    if (disp_n_d != 2'd0)
                        state_d = S_DISP;
                    else if (imm_n_d != 3'd0)
                        state_d = S_IMM;
                    else
                        state_d = S_HOLD;
                end
                S_DISP: begin
                    // Low byte sign-extends; a disp16 high byte overwrites it.
                    if (cnt_q == 2'd0)
                        f_d.disp = {{8{ib[7]}}, ib};
                    else
                        f_d.disp[15:8] = ib;
                    if (cnt_q + 2'd1 == disp_n_q) begin
                        cnt_d   = 2'd0;
                        state_d = (imm_n_q != 3'd0) ? S_IMM : S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                S_IMM: begin
                    unique case (cnt_q)
                        2'd0: f_d.imm = sx ? {{8{ib[7]}}, ib} : {8'h00, ib};
                        2'd1: f_d.imm[15:8] = ib;
                        2'd2: f_d.imm2 = {8'h00, ib};
                        2'd3: f_d.imm2[15:8] = ib;
                    endcase
                    if ({1'b0, cnt_q} + 3'd1 == imm_n_q)
                        state_d = S_HOLD;
                    else
                        cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
            if (state_d == S_HOLD)
                valid_d = 1'b1;
        end

        // Reload request lasts through the first ce_1 after the branch.
        if (ce_1)
            pfp_d = 1'b0;

        if (br_req && (ce_1 || ce_2)) begin
            head_d   = br_target;
            pfp_d    = 1'b1;
            valid_d  = 1'b0;
            f_d      = '0;
            state_d  = S_PREFIX;
            disp_n_d = 2'd0;
            imm_n_d  = 3'd0;
            cnt_d    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= S_PREFIX;
            head_q   <= RESET_PC;
            pfp_q    <= 1'b0;
            valid_q  <= 1'b0;
            f_q      <= '0;
            disp_n_q <= 2'd0;
            imm_n_q  <= 3'd0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            pfp_q    <= pfp_d;
            valid_q  <= valid_d;
            f_q      <= f_d;
            disp_n_q <= disp_n_d;
            imm_n_q  <= imm_n_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ipq_head      = head_q;
    assign pfp_set       = pfp_q;
    assign dec_valid     = valid_q;
    assign dec_pc        = f_q.pc;
    assign dec_len       = f_q.len;
    assign dec_seg       = f_q.seg;
    assign dec_rep       = f_q.rep;
    assign dec_lock      = f_q.lock;
    assign dec_opcode    = f_q.opcode;
    assign dec_has_modrm = f_q.has_modrm;
    assign dec_modrm     = f_q.modrm;
    assign dec_disp      = f_q.disp;
    assign dec_imm       = f_q.imm;
    assign dec_imm2      = f_q.imm2;
    assign dec_illegal   = f_q.illegal;

endmodule

// File: tb/tb_instruction_predecoder.sv
// Bench for instruction_predecoder: bus-unit queue model feeding a byte
// image, expected instructions queued and compared on each accept.
`timescale 1ns/1ps
module tb_instruction_predecoder;

    logic            clk = 1'b0;
    logic            n_reset;
    logic            ce_1, ce_2;
    logic [7:0][7:0] ipq;
    logic [3:0]      ipq_len;
    logic [15:0]     ipq_head;
    logic            pfp_set;
    logic            br_req;
    logic [15:0]     br_target;
    logic            dec_valid, dec_ready;
    logic [15:0]     dec_pc;
    logic [3:0]      dec_len;
    logic [2:0]      dec_seg;
    logic [1:0]      dec_rep;
    logic            dec_lock;
    logic [7:0]      dec_opcode;
    logic            dec_has_modrm;
    logic [7:0]      dec_modrm;
    logic [15:0]     dec_disp, dec_imm, dec_imm2;
    logic            dec_illegal;

    instruction_predecoder #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2),
        .ipq(ipq), .ipq_len(ipq_len), .ipq_head(ipq_head),
        .pfp_set(pfp_set), .br_req(br_req), .br_target(br_target),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_len(dec_len), .dec_seg(dec_seg),
        .dec_rep(dec_rep), .dec_lock(dec_lock),
        .dec_opcode(dec_opcode), .dec_has_modrm(dec_has_modrm),
        .dec_modrm(dec_modrm), .dec_disp(dec_disp), .dec_imm(dec_imm),
        .dec_imm2(dec_imm2), .dec_illegal(dec_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  len;
        logic [2:0]  seg;
        logic [1:0]  rep;
        logic        lock;
        logic [7:0]  op;
        logic        hm;
        logic [7:0]  modrm;
        logic [15:0] disp;
        logic [15:0] imm;
        logic [15:0] imm2;
        logic        ill;
        logic [15:0] head;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [0:65535];
    logic [15:0] wp, prog_end;
    bit          gap;
    int          gcnt;
    int          n_chk, n_fail;
    int          used;
    exp_t        e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic exp_t ex(input logic [15:0] pc, input logic [3:0] len,
                                input logic [7:0] op, input logic [15:0] head);
        exp_t r;
        r      = '0;
        r.pc   = pc;
        r.len  = len;
        r.op   = op;
        r.head = head;
        return r;
    endfunction

    task automatic org(input logic [15:0] a);
        wp       = a;
        prog_end = a;
    endtask

    // Append n bytes, listed most significant first in v.
    task automatic bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = v[8*(n-1-i) +: 8];
            wp      = wp + 16'd1;
        end
        prog_end = wp;
    endtask

    task automatic feed();
        logic [2:0]  off;
        logic [15:0] av;
        for (int k = 0; k < 8; k++) begin
            off    = 3'(k) - ipq_head[2:0];
            ipq[k] = mem[ipq_head + {13'd0, off}];
        end
        av = prog_end - ipq_head;
        if (pfp_set || (gap && (gcnt % 3 != 0)))
            ipq_len = 4'd0;
        else
            ipq_len = (av > 16'd8) ? 4'd8 : av[3:0];
    endtask

    task automatic compare(input exp_t x);
        chk("pc", 32'(dec_pc), 32'(x.pc));
        chk("len", 32'(dec_len), 32'(x.len));
        chk("seg", 32'(dec_seg), 32'(x.seg));
        chk("rep", 32'(dec_rep), 32'(x.rep));
        chk("lock", 32'(dec_lock), 32'(x.lock));
        chk("opcode", 32'(dec_opcode), 32'(x.op));
        chk("has_modrm", 32'(dec_has_modrm), 32'(x.hm));
        chk("modrm", 32'(dec_modrm), 32'(x.modrm));
        chk("disp", 32'(dec_disp), 32'(x.disp));
        chk("imm", 32'(dec_imm), 32'(x.imm));
        chk("imm2", 32'(dec_imm2), 32'(x.imm2));
        chk("illegal", 32'(dec_illegal), 32'(x.ill));
        chk("head", 32'(ipq_head), 32'(x.head));
    endtask

    task automatic cyc(input bit c1);
        exp_t        x;
        logic [15:0] hb;
        bit          st;
        @(negedge clk);
        ce_1 = c1;
        ce_2 = !c1;
        if (c1)
            gcnt++;
        feed();
        st = c1 && gap && (ipq_len == 4'd0) && !br_req;
        hb = ipq_head;
        if (c1 && dec_valid && dec_ready && !br_req) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(dec_valid), 32'h0);
            end else begin
                x = sb.pop_front();
                compare(x);
            end
        end
        @(posedge clk);
        #1;
        if (st)
            chk("stall_head", 32'(ipq_head), 32'(hb));
    endtask

    task automatic strobe();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            strobe();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        ce_1    = 1'b0;
        ce_2    = 1'b0;
        br_req  = 1'b0;
        gap     = 1'b0;
        gcnt    = 0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic branch(input logic [15:0] tgt);
        @(negedge clk);
        ce_1      = 1'b1;
        ce_2      = 1'b0;
        br_req    = 1'b1;
        br_target = tgt;
        feed();
        @(posedge clk);
        #1;
        br_req = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        n_reset   = 1'b0;
        ce_1      = 1'b0;
        ce_2      = 1'b0;
        br_req    = 1'b0;
        br_target = 16'h0000;
        dec_ready = 1'b1;
        ipq       = '0;
        ipq_len   = 4'd0;
        gap       = 1'b0;
        gcnt      = 0;
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'h00;
        org(16'h0000);

        // reset state
        do_reset();
        #1;
        chk("rst_head", 32'(ipq_head), 32'h0);
        chk("rst_pfp", 32'(pfp_set), 32'h0);
        chk("rst_valid", 32'(dec_valid), 32'h0);
        chk("rst_len", 32'(dec_len), 32'h0);
        chk("rst_opcode", 32'(dec_opcode), 32'h0);

        // single-byte NOP
        org(16'h0000);
        bytes(64'h90, 1);
        sb.push_back(ex(16'h0000, 4'd1, 8'h90, 16'h0001));
        drain(10, used);

        // segment prefix + ModRM + disp8
        do_reset();
        org(16'h0000);
        bytes(64'h2E8B46FE, 4);
        e = ex(16'h0000, 4'd4, 8'h8B, 16'h0004);
        e.seg = 3'b101; e.hm = 1'b1; e.modrm = 8'h46; e.disp = 16'hFFFE;
        sb.push_back(e);
        drain(15, used);

        // disp16 + imm16, then the same bytes with starvation gaps
        for (int g = 0; g < 2; g++) begin
            do_reset();
            gap = (g == 1);
            org(16'h0000);
            bytes(64'h818634127856, 6);
            e = ex(16'h0000, 4'd6, 8'h81, 16'h0006);
            e.hm = 1'b1; e.modrm = 8'h86; e.disp = 16'h1234; e.imm = 16'h5678;
            sb.push_back(e);
            drain(40, used);
            gap = 1'b0;
        end

        // far jump held with dec_ready low
        do_reset();
        dec_ready = 1'b0;
        org(16'h0000);
        bytes(64'hEA001000F0, 5);
        for (int i = 0; i < 20 && !dec_valid; i++)
            strobe();
        chk("ea_valid", 32'(dec_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            strobe();
            chk("hold_valid", 32'(dec_valid), 32'h1);
            chk("hold_head", 32'(ipq_head), 32'h5);
        end
        dec_ready = 1'b1;
        e = ex(16'h0000, 4'd5, 8'hEA, 16'h0005);
        e.imm = 16'h1000; e.imm2 = 16'hF000;
        sb.push_back(e);
        drain(5, used);

        // branch mid-instruction
        do_reset();
        org(16'h0000);
        bytes(64'h818634127856, 6);
        repeat (2) strobe();
        chk("pre_br_head", 32'(ipq_head), 32'h2);
        org(16'h0100);
        bytes(64'h047F, 2);
        branch(16'h0100);
        chk("br_pfp", 32'(pfp_set), 32'h1);
        chk("br_head", 32'(ipq_head), 32'h0100);
        chk("br_valid", 32'(dec_valid), 32'h0);
        chk("br_len", 32'(dec_len), 32'h0);
        cyc(1'b0);
        chk("br_pfp_ce2", 32'(pfp_set), 32'h1);
        cyc(1'b1);
        chk("br_pfp_clr", 32'(pfp_set), 32'h0);
        chk("br_head_held", 32'(ipq_head), 32'h0100);
        chk("br_valid_held", 32'(dec_valid), 32'h0);
        e = ex(16'h0100, 4'd2, 8'h04, 16'h0102);
        e.imm = 16'h007F;
        sb.push_back(e);
        drain(10, used);

        // rep prefixes across the FFFF wrap
        do_reset();
        org(16'hFFFE);
        bytes(64'hF3F2A4, 3);
        branch(16'hFFFE);
        e = ex(16'hFFFE, 4'd3, 8'hA4, 16'h0001);
        e.rep = 2'b10;
        sb.push_back(e);
        drain(10, used);

        // back-to-back single-byte ops: no bubble between accepts
        do_reset();
        org(16'h0000);
        bytes(64'h904048C3, 4);
        sb.push_back(ex(16'h0000, 4'd1, 8'h90, 16'h0001));
        sb.push_back(ex(16'h0001, 4'd1, 8'h40, 16'h0002));
        sb.push_back(ex(16'h0002, 4'd1, 8'h48, 16'h0003));
        sb.push_back(ex(16'h0003, 4'd1, 8'hC3, 16'h0004));
        drain(20, used);
        chk("bubble_strobes", 32'(used), 32'h5);

        // mixed stream: 0F, F6 /0, sign-extended imm8, ENTER,
        // F7 /2, stacked prefixes, saturating length
        do_reset();
        org(16'h0000);
        bytes(64'h0FF606341256, 6);
        bytes(64'h83C0FF, 3);
        bytes(64'hC8100002, 4);
        bytes(64'hF7D0, 2);
        bytes(64'h36F0268A07, 5);
        bytes(64'h3E3E3E3E3E3E3E3E, 8);
        bytes(64'h3E3E3E3E3E3E3E90, 8);
        e = ex(16'h0000, 4'd1, 8'h0F, 16'h0001);
        e.ill = 1'b1;
        sb.push_back(e);
        e = ex(16'h0001, 4'd5, 8'hF6, 16'h0006);
        e.hm = 1'b1; e.modrm = 8'h06; e.disp = 16'h1234; e.imm = 16'h0056;
        sb.push_back(e);
        e = ex(16'h0006, 4'd3, 8'h83, 16'h0009);
        e.hm = 1'b1; e.modrm = 8'hC0; e.imm = 16'hFFFF;
        sb.push_back(e);
        e = ex(16'h0009, 4'd4, 8'hC8, 16'h000D);
        e.imm = 16'h0010; e.imm2 = 16'h0002;
        sb.push_back(e);
        e = ex(16'h000D, 4'd2, 8'hF7, 16'h000F);
        e.hm = 1'b1; e.modrm = 8'hD0;
        sb.push_back(e);
        e = ex(16'h000F, 4'd5, 8'h8A, 16'h0014);
        e.seg = 3'b100; e.lock = 1'b1; e.hm = 1'b1; e.modrm = 8'h07;
        sb.push_back(e);
        e = ex(16'h0014, 4'd15, 8'h90, 16'h0024);
        e.seg = 3'b111;
        sb.push_back(e);
        drain(60, used);

        // asynchronous reset mid-instruction
        do_reset();
        org(16'h0000);
        bytes(64'h818634, 3);
        repeat (2) strobe();
        chk("mid_len", 32'(dec_len), 32'h2);
        #2;
        n_reset = 1'b0;
        #1;
        chk("mid_rst_head", 32'(ipq_head), 32'h0);
        chk("mid_rst_len", 32'(dec_len), 32'h0);
        chk("mid_rst_opcode", 32'(dec_opcode), 32'h0);
        chk("mid_rst_modrm", 32'(dec_modrm), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
